// File: rtl/kd_tree_sequencer_pkg.sv
// Shared types and default widths for the kd-tree load/query sequencer.
package kd_tree_pkg;

  localparam int DSIZE_DEF         = 11;
  localparam int FETCH_WIDTH_DEF   = 2;
  localparam int ADDRESS_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_QUERY = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/kd_tree_sequencer_issue_tracker.sv
// Valid-bit pipeline that mirrors the tree latency; out marks the cycle a leaf
// index belonging to an earlier issue is present on the tree output.
module issue_tracker #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic wrst_n,
  input  logic in,
  output logic out,
  output logic empty
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!wrst_n) sr <= '0;
    else         sr <= (sr << 1) | DEPTH'(in);
  end

  assign out   = sr[DEPTH-1];
  assign empty = ~|sr;

endmodule

// File: rtl/kd_tree_sequencer.sv
// Loads aggregated kd-tree node words into node memory, then streams query
// patches through the tree and forwards leaf indices to the result queue.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting LOAD_WORDS node words into node memory
// QUERY | issuing NUM_PATCHES patches to the tree
// DRAIN | waiting for in-flight leaf indices to leave the pipeline
// DONE  | one-cycle completion pulse
module kd_tree_sequencer
  import kd_tree_pkg::*;
#(
  parameter int DSIZE         = DSIZE_DEF,
  parameter int FETCH_WIDTH   = FETCH_WIDTH_DEF,
  parameter int LOAD_WORDS    = 128,
  parameter int PATCH_WIDTH   = 55,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int NUM_PATCHES   = 1024,
  parameter int TREE_LATENCY  = 8,
  localparam int WAW = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1
) (
  input  logic                           clk,
  input  logic                           wrst_n,
  input  logic                           start,
  input  logic [FETCH_WIDTH*DSIZE-1:0]   agg_data,
  input  logic                           agg_valid,
  output logic                           agg_ready,
  output logic                           node_wr_en,
  output logic [WAW-1:0]                 node_wr_addr,
  output logic [FETCH_WIDTH*DSIZE-1:0]   node_wr_data,
  input  logic [PATCH_WIDTH-1:0]         patch_data,
  input  logic                           patch_valid,
  output logic                           patch_ready,
  output logic [PATCH_WIDTH-1:0]         tree_patch,
  output logic                           tree_enable,
  input  logic [ADDRESS_WIDTH-1:0]       tree_leaf,
  input  logic                           result_full_n,
  output logic                           result_enq,
  output logic [ADDRESS_WIDTH-1:0]       result_leaf,
  output logic                           busy,
  output logic                           done,
  output logic [2:0]                     state
);

  // Counters are one bit wider than needed for addressing so the terminal
  // increment lands on LOAD_WORDS / NUM_PATCHES instead of wrapping.
  localparam int WCW = $clog2(LOAD_WORDS + 1);
  localparam int PCW = $clog2(NUM_PATCHES + 1);

  state_t         st;
  logic [WCW-1:0] word_cnt;
  logic [PCW-1:0] patch_cnt;
  logic           wr_fire;
  logic           issue;
  logic           last_word;
  logic           last_patch;
  logic           trk_out;
  logic           trk_empty;

  assign agg_ready    = (st == S_LOAD);
  assign wr_fire      = agg_ready && agg_valid;
  assign node_wr_en   = wr_fire;
  assign node_wr_addr = wr_fire ? word_cnt[WAW-1:0] : '0;
  assign node_wr_data = wr_fire ? agg_data : '0;

  assign patch_ready  = (st == S_QUERY) && result_full_n;
  assign issue        = patch_valid && patch_ready;

  assign last_word    = (word_cnt == WCW'(LOAD_WORDS - 1));
  assign last_patch   = (patch_cnt == PCW'(NUM_PATCHES - 1));

  // Results are never back-pressured; the queue reserves TREE_LATENCY slack.
  assign result_enq   = trk_out;
  assign result_leaf  = trk_out ? tree_leaf : '0;

  assign busy  = (st != S_IDLE);
  assign done  = (st == S_DONE);
  assign state = st;

  issue_tracker #(.DEPTH(TREE_LATENCY)) u_tracker (
    .clk    (clk),
    .wrst_n (wrst_n),
    .in     (issue),
    .out    (trk_out),
    .empty  (trk_empty)
  );

  always_ff @(posedge clk) begin
    if (!wrst_n) begin
      st          <= S_IDLE;
      word_cnt    <= '0;
      patch_cnt   <= '0;
      tree_patch  <= '0;
      tree_enable <= 1'b0;
    end else begin
      tree_enable <= issue;
      if (issue) tree_patch <= patch_data;
      case (st)
        S_IDLE: begin
          word_cnt  <= '0;
          patch_cnt <= '0;
          if (start) st <= S_LOAD;
        end
        S_LOAD: begin
          if (wr_fire) begin
            word_cnt <= word_cnt + WCW'(1);
            if (last_word) st <= S_QUERY;
          end
        end
        S_QUERY: begin
          if (issue) begin
            patch_cnt <= patch_cnt + PCW'(1);
            if (last_patch) st <= S_DRAIN;
          end
        end
        S_DRAIN: if (trk_empty) st <= S_DONE;
        S_DONE:  st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kd_tree_sequencer.sv
// Scoreboard bench: stimulus pushes expected node writes and leaf results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_kd_tree_sequencer;
  import kd_tree_pkg::*;

  localparam int DS = 11, FW = 2, LW = 4, PW = 55, AW = 8, NP = 4, TL = 8;
  localparam int DW = FW * DS;

  logic          clk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] agg_data = '0;
  logic          agg_valid = 1'b0;
  logic          agg_ready;
  logic          node_wr_en;
  logic [1:0]    node_wr_addr;
  logic [DW-1:0] node_wr_data;
  logic [PW-1:0] patch_data = '0;
  logic          patch_valid = 1'b0;
  logic          patch_ready;
  logic [PW-1:0] tree_patch;
  logic          tree_enable;
  logic [AW-1:0] tree_leaf = '0;
  logic          result_full_n = 1'b1;
  logic          result_enq;
  logic [AW-1:0] result_leaf;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  kd_tree_sequencer #(
    .DSIZE(DS), .FETCH_WIDTH(FW), .LOAD_WORDS(LW), .PATCH_WIDTH(PW),
    .ADDRESS_WIDTH(AW), .NUM_PATCHES(NP), .TREE_LATENCY(TL)
  ) dut (
    .clk(clk), .wrst_n(wrst_n), .start(start),
    .agg_data(agg_data), .agg_valid(agg_valid), .agg_ready(agg_ready),
    .node_wr_en(node_wr_en), .node_wr_addr(node_wr_addr), .node_wr_data(node_wr_data),
    .patch_data(patch_data), .patch_valid(patch_valid), .patch_ready(patch_ready),
    .tree_patch(tree_patch), .tree_enable(tree_enable),
    .tree_leaf(tree_leaf), .result_full_n(result_full_n),
    .result_enq(result_enq), .result_leaf(result_leaf),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] leaf; int due; } res_t;
  typedef struct { logic [1:0] addr; logic [DW-1:0] data; } wr_t;

  res_t          exp_q[$];
  wr_t           wr_q[$];
  logic [AW-1:0] sched[int];
  res_t          e;
  wr_t           w;

  int checks = 0, errors = 0, cyc = 0;
  int wr_count = 0, enq_count = 0, done_count = 0, last_enq_cyc = 0, done_cyc = 0;

  // Stand-in for the tree: any patch yields a fixed hash of itself.
  function automatic logic [AW-1:0] leaf_of(input logic [PW-1:0] p);
    return p[7:0] ^ p[30:23] ^ p[54:47] ^ 8'hA5;
  endfunction

  function automatic logic [PW-1:0] rand_patch();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tree model: leaf for a patch enabled in cycle c is presented in cycle
  // c+TL-1, i.e. TL cycles after the issue; other cycles carry noise.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    tree_leaf = sched.exists(cyc) ? sched[cyc] : AW'($urandom);
  end

  always @(negedge clk) begin
    if (wrst_n) begin
      if (node_wr_en) begin
        wr_count++;
        chk("wr_needs_valid", 64'(agg_valid), 64'd1);
        chk("wr_pending", 64'(wr_q.size() > 0), 64'd1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", 64'(node_wr_addr), 64'(w.addr));
          chk("wr_data", 64'(node_wr_data), 64'(w.data));
        end
      end
      if (tree_enable) sched[cyc + TL - 1] = leaf_of(tree_patch);
      if (patch_valid && patch_ready) begin
        chk("ready_needs_full_n", 64'(result_full_n), 64'd1);
        exp_q.push_back('{leaf_of(patch_data), cyc + TL});
      end
      if (result_enq) begin
        enq_count++;
        last_enq_cyc = cyc;
        chk("res_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("res_leaf", 64'(result_leaf), 64'(e.leaf));
          chk("res_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic load_words(input bit rnd);
    logic acc;
    int n;
    for (int i = 0; i < LW; i++) begin
      agg_data = rnd ? DW'($urandom) : DW'(i + 1);
      wr_q.push_back('{2'(i), agg_data});
      n = 0;
      do begin
        agg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        acc = agg_valid && agg_ready;
        tick();
        n++;
      end while (!acc && n < 100);
      if (!acc) chk("load_timeout", 64'(n), 64'd0);
    end
    agg_valid = 1'b0;
  endtask

  task automatic run_patches(input bit rnd, input bit stall);
    int  issued = 0, n = 0, enq0;
    bit  stalled = 0;
    logic acc;
    patch_data = rand_patch();
    while (issued < NP && n < 300) begin
      patch_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = patch_valid && patch_ready;
      tick();
      n++;
      if (acc) begin
        issued++;
        patch_data = rand_patch();
      end
      if (stall && issued == 2 && !stalled) begin
        stalled = 1;
        patch_valid = 1'b0;
        repeat (4) tick();
        enq0 = enq_count;
        result_full_n = 1'b0;
        patch_valid = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_ready", 64'(patch_ready), 64'd0);
          tick();
          start = 1'b0;
        end
        result_full_n = 1'b1;
        chk("stall_enq_continues", 64'(enq_count > enq0), 64'd1);
      end
    end
    patch_valid = 1'b0;
    chk("patches_issued", 64'(issued), 64'(NP));
  endtask

  task automatic finish_pass(input int done0, input int wr0, input int enq0);
    int n = 0;
    while (done_count == done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_count > done0), 64'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("single_done", 64'(done_count - done0), 64'd1);
    chk("idle_after", 64'(state), 64'(S_IDLE));
    chk("busy_after", 64'(busy), 64'd0);
    chk("writes_per_pass", 64'(wr_count - wr0), 64'(LW));
    chk("results_per_pass", 64'(enq_count - enq0), 64'(NP));
    chk("sb_empty", 64'(exp_q.size() + wr_q.size()), 64'd0);
    tick();
  endtask

  task automatic random_pass();
    int d0, w0, q0;
    d0 = done_count; w0 = wr_count; q0 = enq_count;
    agg_valid = 1'b1;
    agg_data  = DW'($urandom);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    load_words(1);
    agg_valid = 1'b1;
    agg_data  = DW'($urandom);
    run_patches(1, 1);
    agg_valid = 1'b0;
    finish_pass(d0, w0, q0);
  endtask

  initial begin
    int d0, w0, q0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_agg_ready", 64'(agg_ready), 64'd0);
    chk("rst_node_wr_en", 64'(node_wr_en), 64'd0);
    chk("rst_node_wr_addr", 64'(node_wr_addr), 64'd0);
    chk("rst_node_wr_data", 64'(node_wr_data), 64'd0);
    chk("rst_patch_ready", 64'(patch_ready), 64'd0);
    chk("rst_tree_patch", 64'(tree_patch), 64'd0);
    chk("rst_tree_enable", 64'(tree_enable), 64'd0);
    chk("rst_result_enq", 64'(result_enq), 64'd0);
    chk("rst_result_leaf", 64'(result_leaf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_state", 64'(state), 64'(S_IDLE));
    tick();
    wrst_n = 1'b1;
    tick();

    // Directed pass: constant agg_valid, back-to-back patches.
    d0 = done_count; w0 = wr_count; q0 = enq_count;
    for (int i = 0; i < LW; i++) wr_q.push_back('{2'(i), DW'(i + 1)});
    start = 1'b1;
    tick();
    start = 1'b0;
    agg_valid = 1'b1;
    for (int i = 0; i < LW; i++) begin
      agg_data = DW'(i + 1);
      @(negedge clk);
      chk("a_wr_en", 64'(node_wr_en), 64'd1);
      chk("a_wr_addr", 64'(node_wr_addr), 64'(i));
      if (i == 0) chk("a_busy_load", 64'(busy), 64'd1);
      tick();
    end
    agg_data = DW'(32'h3FF);
    @(negedge clk);
    chk("a_query_5th", 64'(state), 64'(S_QUERY));
    chk("a_agg_ready_off", 64'(agg_ready), 64'd0);
    tick();
    agg_valid = 1'b0;
    run_patches(0, 0);
    finish_pass(d0, w0, q0);
    chk("a_done_after_drain", 64'(done_cyc), 64'(last_enq_cyc + 2));

    // Random passes with a result-queue stall and a stray start in QUERY.
    random_pass();
    random_pass();

    // Reset in DRAIN with the full pass still in flight.
    d0 = done_count; q0 = enq_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_words(0);
    run_patches(0, 0);
    wrst_n = 1'b0;
    @(negedge clk);
    chk("c_in_drain", 64'(state), 64'(S_DRAIN));
    tick();
    exp_q.delete();
    wr_q.delete();
    sched.delete();
    @(negedge clk);
    chk("c_idle_after_rst", 64'(state), 64'(S_IDLE));
    chk("c_busy_after_rst", 64'(busy), 64'd0);
    tick();
    wrst_n = 1'b1;
    repeat (15) tick();
    chk("c_no_enq_after_rst", 64'(enq_count - q0), 64'd0);
    chk("c_no_done_after_rst", 64'(done_count - d0), 64'd0);

    random_pass();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
